// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and constants for the I2C register target
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
    } i2c_state_t;
    localparam logic ACK = 1'b0;
    localparam logic NACK = 1'b1;
    localparam logic [6:0] I2C_DEF_ADDR = 7'h2A;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronise SCL/SDA and decode edges and bus conditions
// Ports: clk, rst_n; scl_i/sda_i raw pad inputs; sda synchronised SDA;
//        scl_rise/scl_fall SCL edges; start_det/stop_det START and STOP.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic scl, scl_h, sda_h;
    // Idle bus level is high, so reset to 1 to avoid a phantom edge after reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_h <= 1'b1;
            sda_h <= 1'b1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl_i};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda_i};
            scl_h <= scl;
            sda_h <= sda;
        end
    assign scl = scl_q[SYNC_STAGES-1];
    assign sda = sda_q[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_h;
    assign scl_fall = ~scl & scl_h;
    assign start_det = scl & scl_h & sda_h & ~sda;
    assign stop_det = scl & scl_h & ~sda_h & sda;
endmodule

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C target decoding write/read transactions onto a byte register port
// Ports: clk, rst_n (async, active low), ena (hold idle when low);
//        scl_i/sda_i pad inputs, sda_oe open-drain pull-low enable;
//        reg_addr/reg_wdata/reg_we/reg_re/reg_rdata register port; busy addressed transfer.
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = I2C_DEF_ADDR,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    i2c_state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shift, shift_n, addr_n, wdata_n;
    logic rw, rw_n, ld, oe_n, busy_n, we_n, re_n, match;
    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda(sda),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det), .stop_det(stop_det)
    );

    assign match = shift[7:1] == I2C_ADDR;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= ena ? state_n : IDLE;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        shift_n = shift;
        rw_n = rw;
        oe_n = sda_oe;
        busy_n = busy;
        addr_n = reg_addr;
        wdata_n = reg_wdata;
        we_n = 1'b0;
        re_n = 1'b0;
        // Pointer advances the clk after a write strobe so the strobe sees the old address
        if (reg_we) addr_n = reg_addr + 8'd1;
        // Read data arrives one clk after reg_re; bit 7 goes straight onto SDA
        if (ld) begin
            shift_n = reg_rdata;
            oe_n = ~reg_rdata[7];
        end
        if (scl_rise && (state == ADDR || state == SUB || state == WR)) begin
            shift_n = {shift[6:0], sda};
            cnt_n = cnt + 4'd1;
        end
        if (start_det) begin
            state_n = ADDR;
            cnt_n = '0;
            oe_n = 1'b0;
        end else if (stop_det) begin
            state_n = IDLE;
            cnt_n = '0;
            oe_n = 1'b0;
            busy_n = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_fall && cnt == 4'd8) begin
                    cnt_n = '0;
                    rw_n = shift[0];
                    oe_n = match;
                    busy_n = busy | match;
                    state_n = match ? ADDR_ACK : IGNORE;
                end
                ADDR_ACK: if (scl_fall) begin
                    // On a read, keep SDA low until the first data bit is loaded
                    oe_n = rw;
                    re_n = rw;
                    state_n = rw ? RD : SUB;
                end
                SUB: if (scl_fall && cnt == 4'd8) begin
                    cnt_n = '0;
                    addr_n = shift;
                    oe_n = 1'b1;
                    state_n = SUB_ACK;
                end
                SUB_ACK, WR_ACK: if (scl_fall) begin
                    oe_n = 1'b0;
                    state_n = WR;
                end
                WR: if (scl_fall && cnt == 4'd8) begin
                    cnt_n = '0;
                    wdata_n = shift;
                    we_n = 1'b1;
                    oe_n = 1'b1;
                    state_n = WR_ACK;
                end
                RD: if (scl_fall) begin
                    cnt_n = cnt + 4'd1;
                    shift_n = {shift[6:0], 1'b0};
                    oe_n = cnt == 4'd7 ? 1'b0 : ~shift[6];
                    state_n = cnt == 4'd7 ? RD_ACK : RD;
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        addr_n = sda == ACK ? reg_addr + 8'd1 : reg_addr;
                        state_n = sda == ACK ? RD_ACK : IGNORE;
                    end
                    if (scl_fall) begin
                        cnt_n = '0;
                        re_n = 1'b1;
                        state_n = RD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            shift <= '0;
            rw <= 1'b0;
            ld <= 1'b0;
            sda_oe <= 1'b0;
            busy <= 1'b0;
            reg_addr <= '0;
            reg_wdata <= '0;
            reg_we <= 1'b0;
            reg_re <= 1'b0;
        end else if (!ena) begin
            cnt <= '0;
            shift <= '0;
            rw <= 1'b0;
            ld <= 1'b0;
            sda_oe <= 1'b0;
            busy <= 1'b0;
            reg_wdata <= '0;
            reg_we <= 1'b0;
            reg_re <= 1'b0;
        end else begin
            cnt <= cnt_n;
            shift <= shift_n;
            rw <= rw_n;
            ld <= reg_re;
            sda_oe <= oe_n;
            busy <= busy_n;
            reg_addr <= addr_n;
            reg_wdata <= wdata_n;
            reg_we <= we_n;
            reg_re <= re_n;
        end
endmodule

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
- I2C target front-end of the dice design.
- Receives SCL/SDA from the bidirectional pads (SCL on uio[3], SDA on uio[2]) and decodes write and read transactions.
- Drives a simple byte-wide register port that feeds the dice core's configuration and result registers.
- Drives SDA low through an open-drain enable for ACKs and for read data.

Parameters:
- I2C_ADDR, 7'h2A, 7-bit target address; the R/W bit is excluded.
- SYNC_STAGES, 2, synchroniser flops on scl_i and sda_i; must be ≥2.

Ports:
- clk  input  1  system clock; must be ≥10× SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; when low, the block is held idle.
- scl_i  input  1  SCL pad input (uio_in[3]).
- sda_i  input  1  SDA pad input (uio_in[2]).
- sda_oe  output  1  1 = pull SDA low; the pad output value is tied 0 outside this block.
- reg_addr  output  8  current sub-address pointer.
- reg_wdata  output  8  write data; valid while reg_we is high.
- reg_we  output  1  one-clk write strobe.
- reg_re  output  1  one-clk read strobe; reg_rdata must be valid on the next clk.
- reg_rdata  input  8  read data from the register bank.
- busy  output  1  high from an addressed START until STOP.

Behaviour:
- Reset values:
  - sda_oe=0, reg_we=0, reg_re=0, busy=0, reg_addr=0, reg_wdata=0.
  - State IDLE; shift register and bit counter cleared.
  - Reset acts immediately mid-transfer and releases SDA.
- ena=0: same as reset, except reg_addr keeps its value.
- Input path:
  - scl_i and sda_i each pass through SYNC_STAGES flops, then one history flop used for edge detection.
  - Both lines use identical delay, so their relative ordering is preserved.
- Bus events:
  - START/RESTART = SDA falling while SCL is high.
  - STOP = SDA rising while SCL is high.
  - Data bits are sampled on SCL rising edges, MSB first.
  - The target changes SDA only on SCL falling edges.
- States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- START from any state → ADDR with the bit counter cleared. STOP from any state → IDLE, busy=0.
- ADDR: after 8 bits, compare bits [7:1] with I2C_ADDR.
  - Match: on the next SCL falling edge set sda_oe=1, set busy=1, go to ADDR_ACK.
  - Mismatch → IGNORE; sda_oe stays 0.
- ADDR_ACK: on the SCL falling edge that ends the ACK clock:
  - sda_oe=0 in the write case.
  - R/W=0 → SUB.
  - R/W=1 → pulse reg_re, load reg_rdata into the shifter one clk later, drive bit 7 (sda_oe = ~bit), go to RD.
- SUB:
  - 8 bits → reg_addr.
  - ACK is driven exactly as in ADDR_ACK.
  - Then → WR.
- WR: after 8 bits:
  - reg_wdata = byte.
  - On the ACK-start falling edge, pulse reg_we for one clk with the current reg_addr.
  - On the following clk, reg_addr increments mod 256 (8'hFF → 8'h00).
  - Drive ACK, then → WR (unbounded burst).
- RD:
  - Shift out 8 bits, with sda_oe = ~bit.
  - After the 8th bit's falling edge, sda_oe=0 and → RD_ACK.
- RD_ACK: sample the master bit on SCL rising.
  - ACK (0): reg_addr increments, then on SCL falling pulse reg_re, load the next byte → RD.
  - NACK (1): → IGNORE until STOP or START.
- RESTART behaviour:
  - reg_addr is preserved across RESTART, so write-sub-address then RESTART-read works.
  - RESTART in the middle of a byte discards the partial byte; no reg_we is issued.
- IGNORE: sda_oe=0; waits only for START or STOP.
- General call (address 0x00) is not acknowledged. Clock stretching is not supported.

Decomposition:
- Package i2c_pkg contains:
  - the state enum (i2c_state_t);
  - the constants ACK=1'b0 and NACK=1'b1;
  - the default address.
- Sub-module i2c_line_sync:
  - synchronisers for both lines;
  - outputs scl_rise, scl_fall, start_det, stop_det, and the synchronised sda.
- The FSM, shifter and pointer logic stay in i2c_reg_slave.

Test Plan:
- Write 0x54 (0x2A,W), sub 0x10, data 0xA5, 0x3C, STOP → ACK on all 4 bytes; reg_we pulses with (0x10,0xA5) and (0x11,0x3C); final reg_addr=0x12; busy drops after STOP.
- Address 0x56 (mismatch) followed by 2 bytes → sda_oe never asserted; no reg_we; busy stays 0.
- Write sub 0x20, RESTART, 0x55 (read), bank returns 0x81 and 0x7E, master ACKs then NACKs, STOP → SDA bits 10000001 then 01111110; reg_re pulsed twice at addresses 0x20 and 0x21.
- Sub 0xFF, then 2 data bytes → writes at 0xFF then 0x00 (wrap).
- rst_n low while the target drives an ACK → sda_oe=0 within the same clk (async); next START is decoded normally.
- STOP after 4 bits of a data byte → no reg_we; state IDLE; busy=0.
